// File: rtl/dmem_ctrl.sv
// Data-memory controller between the MIPS core memory port and a variable-
// latency req/ack memory bus. A single-entry posted-write buffer lets stores
// retire without stalling; loads stall the core until their data returns.
module dmem_ctrl #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic [ADDR_W-1:0] ALUResult,
    input  logic [DATA_W-1:0] ReadData2,
    output logic [DATA_W-1:0] ReadData,
    output logic              Stall,
    output logic              AddrErr,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-3:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WR    = 2'd1,
        RD    = 2'd2,
        RDONE = 2'd3
    } state_t;

    state_t            state;
    logic              wb_valid;
    logic [ADDR_W-3:0] wb_addr;
    logic [DATA_W-1:0] wb_data;
    logic [ADDR_W-3:0] rd_addr;

    logic illegal;
    logic ld_ok;
    logic st_ok;
    logic ack;

    // The buffer registers drive the bus directly; mem_we doubles as the
    // buffer-occupied flag so the write fields are only presented in WR.
    assign mem_we    = wb_valid;
    assign mem_addr  = wb_valid ? wb_addr : rd_addr;
    assign mem_wdata = wb_data;

    // Request decode: classify the core request and qualify mem_ack.
    always_comb begin
        illegal = ((MemRead | MemWrite) && (ALUResult[1:0] != 2'b00)) ||
                  (MemRead && MemWrite);
        ld_ok   = MemRead  && !illegal;
        st_ok   = MemWrite && !illegal;
        ack     = mem_ack && mem_req;
    end

    // Stall/AddrErr: combinational handshake back to the core.
    always_comb begin
        Stall   = 1'b0;
        AddrErr = 1'b0;
        if (rst) begin
            AddrErr = illegal;
            unique case (state)
                IDLE:    Stall = ld_ok;
                WR:      Stall = ack ? ld_ok : (ld_ok || st_ok);
                RD:      Stall = 1'b1;
                RDONE:   Stall = 1'b0;
                default: Stall = 1'b0;
            endcase
        end
    end

    // Controller FSM with registered bus outputs, write buffer and load data.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            wb_valid <= 1'b0;
            wb_addr  <= '0;
            wb_data  <= '0;
            rd_addr  <= '0;
            mem_req  <= 1'b0;
            ReadData <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (st_ok) begin
                        wb_valid <= 1'b1;
                        wb_addr  <= ALUResult[ADDR_W-1:2];
                        wb_data  <= ReadData2;
                        mem_req  <= 1'b1;
                        state    <= WR;
                    end else if (ld_ok) begin
                        rd_addr  <= ALUResult[ADDR_W-1:2];
                        mem_req  <= 1'b1;
                        state    <= RD;
                    end
                end
                WR: begin
                    if (ack) begin
                        if (st_ok) begin
                            // Refill the buffer in the ack cycle so the next
                            // write follows with no gap in mem_req.
                            wb_addr <= ALUResult[ADDR_W-1:2];
                            wb_data <= ReadData2;
                        end else if (ld_ok) begin
                            wb_valid <= 1'b0;
                            rd_addr  <= ALUResult[ADDR_W-1:2];
                            state    <= RD;
                        end else begin
                            wb_valid <= 1'b0;
                            mem_req  <= 1'b0;
                            state    <= IDLE;
                        end
                    end
                end
                RD: begin
                    if (ack) begin
                        ReadData <= mem_rdata;
                        mem_req  <= 1'b0;
                        state    <= RDONE;
                    end
                end
                RDONE: begin
                    // The core still shows the completed load here; ignore it.
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed testbench for dmem_ctrl: inputs change 1 ns after the rising
// edge, outputs are checked on the falling edge.
module tb_dmem_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] ALUResult;
    logic [31:0] ReadData2;
    logic [31:0] ReadData;
    logic        Stall;
    logic        AddrErr;
    logic        mem_req;
    logic        mem_we;
    logic [29:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    int total = 0;
    int fails = 0;

    dmem_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .MemRead   (MemRead),
        .MemWrite  (MemWrite),
        .ALUResult (ALUResult),
        .ReadData2 (ReadData2),
        .ReadData  (ReadData),
        .Stall     (Stall),
        .AddrErr   (AddrErr),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic chk_bus(input string tag, input logic req, input logic we,
                           input logic [29:0] addr, input logic [31:0] wdata);
        chk({tag, ".mem_req"}, 64'(mem_req), 64'(req));
        chk({tag, ".mem_we"}, 64'(mem_we), 64'(we));
        chk({tag, ".mem_addr"}, 64'(mem_addr), 64'(addr));
        chk({tag, ".mem_wdata"}, 64'(mem_wdata), 64'(wdata));
    endtask

    initial begin
        rst = 1'b0; MemRead = 1'b0; MemWrite = 1'b1;
        ALUResult = 32'h100; ReadData2 = 32'h1234_5678;
        mem_ack = 1'b0; mem_rdata = '0;

        // Reset held two cycles with a store request present
        for (int i = 0; i < 2; i++) begin
            next_cycle();
            sample();
            chk_bus("rst", 1'b0, 1'b0, 30'h0, 32'h0);
            chk("rst.ReadData", 64'(ReadData), 64'h0);
            chk("rst.Stall", 64'(Stall), 64'h0);
            chk("rst.AddrErr", 64'(AddrErr), 64'h0);
        end
        next_cycle();
        rst = 1'b1; MemWrite = 1'b0;
        sample();
        chk("idle.Stall", 64'(Stall), 64'h0);
        chk("idle.mem_req", 64'(mem_req), 64'h0);

        // Posted store, ack in the third request cycle
        next_cycle();
        MemWrite = 1'b1; ALUResult = 32'h100; ReadData2 = 32'hDEAD_BEEF;
        sample();
        chk("st1.Stall", 64'(Stall), 64'h0);
        chk("st1.mem_req0", 64'(mem_req), 64'h0);
        for (int i = 1; i <= 3; i++) begin
            next_cycle();
            MemWrite = 1'b0;
            mem_ack = (i == 3);
            sample();
            chk("st1.Stall_wr", 64'(Stall), 64'h0);
            chk_bus("st1.bus", 1'b1, 1'b1, 30'h40, 32'hDEAD_BEEF);
        end
        next_cycle();
        mem_ack = 1'b0;
        sample();
        chk("st1.mem_req_end", 64'(mem_req), 64'h0);

        // Store then immediate load of the same word, latency 1
        next_cycle();
        MemWrite = 1'b1; ALUResult = 32'h100; ReadData2 = 32'hDEAD_BEEF;
        sample();
        chk("sl.st_Stall", 64'(Stall), 64'h0);
        next_cycle();
        MemWrite = 1'b0; MemRead = 1'b1; mem_ack = 1'b1;
        sample();
        chk("sl.wack_Stall", 64'(Stall), 64'h1);
        chk_bus("sl.wr", 1'b1, 1'b1, 30'h40, 32'hDEAD_BEEF);
        next_cycle();
        mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        sample();
        chk("sl.rack_Stall", 64'(Stall), 64'h1);
        chk("sl.rd_req", 64'(mem_req), 64'h1);
        chk("sl.rd_we", 64'(mem_we), 64'h0);
        chk("sl.rd_addr", 64'(mem_addr), 64'h40);
        next_cycle();
        mem_ack = 1'b0; mem_rdata = 32'h0;
        sample();
        chk("sl.done_Stall", 64'(Stall), 64'h0);
        chk("sl.ReadData", 64'(ReadData), 64'hDEAD_BEEF);
        chk("sl.done_req", 64'(mem_req), 64'h0);
        next_cycle();
        MemRead = 1'b0;
        sample();
        chk("sl.no_reissue", 64'(mem_req), 64'h0);

        // Back-to-back stores, latency 2
        next_cycle();
        MemWrite = 1'b1; ALUResult = 32'h4; ReadData2 = 32'h1111_1111;
        sample();
        chk("bb.st1_Stall", 64'(Stall), 64'h0);
        next_cycle();
        ALUResult = 32'h8; ReadData2 = 32'h2222_2222;
        sample();
        chk("bb.st2_Stall", 64'(Stall), 64'h1);
        chk_bus("bb.w1a", 1'b1, 1'b1, 30'h1, 32'h1111_1111);
        next_cycle();
        mem_ack = 1'b1;
        sample();
        chk("bb.cap_Stall", 64'(Stall), 64'h0);
        chk_bus("bb.w1b", 1'b1, 1'b1, 30'h1, 32'h1111_1111);
        next_cycle();
        MemWrite = 1'b0; mem_ack = 1'b0;
        sample();
        chk_bus("bb.w2a", 1'b1, 1'b1, 30'h2, 32'h2222_2222);
        next_cycle();
        mem_ack = 1'b1;
        sample();
        chk_bus("bb.w2b", 1'b1, 1'b1, 30'h2, 32'h2222_2222);
        next_cycle();
        mem_ack = 1'b0;
        sample();
        chk("bb.end_req", 64'(mem_req), 64'h0);
        chk("bb.end_Stall", 64'(Stall), 64'h0);

        // Illegal requests
        next_cycle();
        MemRead = 1'b1; ALUResult = 32'h102;
        sample();
        chk("ill.mis_AddrErr", 64'(AddrErr), 64'h1);
        chk("ill.mis_Stall", 64'(Stall), 64'h0);
        next_cycle();
        MemWrite = 1'b1; ALUResult = 32'h100;
        sample();
        chk("ill.both_AddrErr", 64'(AddrErr), 64'h1);
        chk("ill.both_Stall", 64'(Stall), 64'h0);
        chk("ill.mis_req", 64'(mem_req), 64'h0);
        next_cycle();
        MemRead = 1'b0; MemWrite = 1'b0;
        sample();
        chk("ill.both_req", 64'(mem_req), 64'h0);
        chk("ill.clear_AddrErr", 64'(AddrErr), 64'h0);

        // Reset while a read is outstanding
        next_cycle();
        MemRead = 1'b1; ALUResult = 32'h200;
        sample();
        chk("rr.ld_Stall", 64'(Stall), 64'h1);
        next_cycle();
        sample();
        chk("rr.rd_req", 64'(mem_req), 64'h1);
        chk("rr.rd_addr", 64'(mem_addr), 64'h80);
        next_cycle();
        rst = 1'b0;
        sample();
        chk("rr.rst_Stall", 64'(Stall), 64'h0);
        next_cycle();
        rst = 1'b1; MemRead = 1'b0;
        sample();
        chk("rr.after_req", 64'(mem_req), 64'h0);
        chk("rr.after_Stall", 64'(Stall), 64'h0);
        chk("rr.ReadData_rst", 64'(ReadData), 64'h0);
        next_cycle();
        MemRead = 1'b1; ALUResult = 32'h204; mem_rdata = 32'hCAFE_F00D;
        sample();
        chk("rr.ld2_Stall", 64'(Stall), 64'h1);
        next_cycle();
        mem_ack = 1'b1;
        sample();
        chk("rr.ld2_Stall_ack", 64'(Stall), 64'h1);
        chk("rr.ld2_req", 64'(mem_req), 64'h1);
        chk("rr.ld2_we", 64'(mem_we), 64'h0);
        chk("rr.ld2_addr", 64'(mem_addr), 64'h81);
        next_cycle();
        mem_ack = 1'b0; mem_rdata = 32'h5555_5555;
        sample();
        chk("rr.ld2_done_Stall", 64'(Stall), 64'h0);
        chk("rr.ld2_ReadData", 64'(ReadData), 64'hCAFE_F00D);

        // Stray ack in IDLE is ignored and ReadData holds
        next_cycle();
        MemRead = 1'b0; mem_ack = 1'b1;
        sample();
        chk("stray.req", 64'(mem_req), 64'h0);
        next_cycle();
        mem_ack = 1'b0;
        sample();
        chk("stray.req2", 64'(mem_req), 64'h0);
        chk("stray.ReadData", 64'(ReadData), 64'hCAFE_F00D);
        chk("stray.Stall", 64'(Stall), 64'h0);

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule

// File: doc/dmem_ctrl.md
# dmem_ctrl

Data-memory controller placed directly downstream of the MIPS core's memory port. It consumes the core's MemRead/MemWrite/ALUResult/ReadData2 and produces ReadData. Toward memory it drives a variable-latency req/ack bus. A single-entry posted-write buffer lets stores retire without stalling, and Stall freezes the core (PC and pipeline state) while a load or a blocked store is outstanding.

## Interface
- ADDR_W, 32, byte-address width of ALUResult; mem_addr is ADDR_W-2 bits (word address)
- DATA_W, 32, data width
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-low reset
- MemRead  in  1  core load request
- MemWrite  in  1  core store request
- ALUResult  in  ADDR_W  byte address from core
- ReadData2  in  DATA_W  store data from core
- ReadData  out  DATA_W  load data to core (registered)
- Stall  out  1  core must hold PC and request inputs stable while 1 (combinational)
- AddrErr  out  1  misaligned or illegal request this cycle (combinational)
- mem_req  out  1  memory request, held until mem_ack
- mem_we  out  1  1 = write, 0 = read; stable while mem_req=1
- mem_addr  out  ADDR_W-2  word address; stable while mem_req=1
- mem_wdata  out  DATA_W  write data; stable while mem_req=1
- mem_ack  in  1  request complete; read data valid on mem_rdata in the same cycle
- mem_rdata  in  DATA_W  read data

## Operation
- State machine states: IDLE, WR (posted write outstanding), RD (read outstanding), RDONE (load data presented).
- Write buffer: wb_valid, wb_addr, wb_data. In WR, mem_addr/mem_wdata come from the buffer.
- Illegal request: ALUResult[1:0] != 0 with MemRead|MemWrite, or MemRead&MemWrite both 1.
  - AddrErr=1 and Stall=0; the request is dropped and state is unchanged.
- IDLE + store: capture address/data into the buffer; Stall=0; go to WR.
- IDLE + load: Stall=1; go to RD with mem_req=1, mem_we=0.
- WR, no mem_ack:
  - A new store or a load gives Stall=1.
- WR, mem_ack=1:
  - A store in the same cycle is captured into the buffer, Stall=0, and the FSM stays in WR. The store is issued without a gap.
  - A pending load gives Stall=1 and the FSM goes to RD.
  - With no request, go to IDLE.
- Loads never bypass the buffer. A load after a store always waits for the drain, so there is no forwarding path.
- RD: Stall=1 until mem_ack. On mem_ack, ReadData <= mem_rdata, mem_req drops, and the FSM goes to RDONE.
- RDONE: Stall=0 and ReadData is valid. The core's MemRead is still high for the same instruction and must not re-issue. Go to IDLE.
- ReadData holds its last load value until the next load completes.

## Timing
- Reset (rst=0 at a clock edge) forces:
  - state IDLE, wb_valid=0
  - mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, ReadData=0
- Stall and AddrErr are forced to 0 while rst=0.
- Reset mid-transaction abandons the outstanding request and the buffered write is lost. The memory side must tolerate a dropped mem_req.
- mem_req, mem_we, mem_addr and mem_wdata are registered. They assert the cycle after the triggering request.
- Store accepted in IDLE at cycle t:
  - Stall=0 at t.
  - mem_req=1, mem_we=1 from t+1 until the ack cycle inclusive.
  - mem_req=0 the cycle after the ack, unless a new store was captured.
- Load in IDLE at cycle t with mem_ack at cycle k ≥ t+1:
  - Stall=1 for cycles t..k.
  - ReadData valid and Stall=0 at k+1.
  - Minimum 2 stall cycles.
- Load behind a posted write: stall extends through the write ack and then the full read latency.
- mem_ack while mem_req=0 is ignored.

## Test plan
- Reset: hold rst=0 for 2 cycles with MemWrite=1 -> all outputs 0, no mem_req; release -> IDLE.
- Store addr 0x100, data 0xDEADBEEF, ack after 3 cycles -> Stall never 1; mem_req=1, mem_we=1, mem_addr=0x40, mem_wdata=0xDEADBEEF for 3 cycles, then mem_req=0.
- Store to 0x100 then immediate load from 0x100, memory returning 0xDEADBEEF, ack latency 1 -> load stalls through the write ack and then the read ack. ReadData=0xDEADBEEF with Stall=0 in the following cycle; exactly one read issued.
- Back-to-back stores to 0x4 and 0x8, ack latency 2 -> second store stalls 1 cycle. It is captured in the ack cycle of the first, and mem_addr changes 0x1 -> 0x2 with no mem_req gap.
- MemRead=1 with ALUResult=0x102 -> AddrErr=1, Stall=0, no mem_req; MemRead=MemWrite=1 -> AddrErr=1.
- rst=0 asserted while in RD with no ack -> mem_req=0 next cycle, Stall=0; a subsequent load issues normally.
